// File: rtl/serial_word_loader_if.sv
// Word hand-off bus between the serial word loader and its consumers:
// serial feed to the 16-bit shift register plus the word valid/ready/address
// handshake used by the program-memory writer.
interface serial_word_loader_if #(
  parameter int ADDR_W = 15
) ();
  logic              shift_in_o;    // serial bit into shift register
  logic              shift_en_o;    // one-cycle shift strobe
  logic              word_valid_o;  // shift register holds a complete word
  logic              word_ready_i;  // consumer takes the word this edge
  logic [ADDR_W-1:0] addr_o;        // write address of current/pending word

  // Loader side drives the feed and the handshake.
  modport master (
    output shift_in_o, shift_en_o, word_valid_o, addr_o,
    input  word_ready_i
  );

  // Consumer side (shift register + memory writer).
  modport slave (
    input  shift_in_o, shift_en_o, word_valid_o, addr_o,
    output word_ready_i
  );
endinterface

// File: rtl/serial_word_loader.sv
// Serial word loader: synchronises an off-chip serial link (sclk/sdi/csb),
// feeds the 16-bit shift register one bit per sclk rise (MSB first), and
// presents each completed word with a write address on a valid/ready
// handshake. Bootstrap path for loading instruction memory.
module serial_word_loader #(
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int ADDR_W      = 15
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 sclk_i,
  input  logic                 sdi_i,
  input  logic                 csb_i,
  input  logic                 clr_i,
  serial_word_loader_if.master bus,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 frame_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;  // csb high, no word pending
  localparam logic [1:0] ST_SHIFT = 2'd1;  // csb low, counting bits
  localparam logic [1:0] ST_HOLD  = 2'd2;  // complete word awaiting accept

  // Synchroniser chains; csb idles high so its chain resets to 1.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic                   r_sclk_prev;

  logic w_sclk;
  logic w_sdi;
  logic w_csb;
  logic w_rise;

  // Control state.
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_shift_in;
  logic              r_shift_en;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_overrun;
  logic              r_frame_err;

  // Next-state values.
  logic [1:0]        w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic              w_shift_in_nxt;
  logic              w_shift_en_nxt;
  logic              w_valid_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_overrun_nxt;
  logic              w_frame_err_nxt;
  logic              w_accept;

  // Bring the three serial-link inputs into the clk domain at equal depth
  // so sdi is sampled with the same delay as the sclk edge it belongs to.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      r_csb_sync  <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0],  sdi_i};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0],  csb_i};
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdi    = r_sdi_sync[SYNC_STAGES-1];
  assign w_csb    = r_csb_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk & ~r_sclk_prev;
  assign w_accept = r_valid & bus.word_ready_i;

  // Frame / word sequencing. HOLD raises valid one cycle after the 16th
  // strobe so the shift register has already taken the last bit. On an
  // accept that coincides with an sclk rise, the bit becomes bit 0 of the
  // next word; its strobe is registered, so it lands after the consumer
  // has sampled the current word.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_in_nxt  = r_shift_in;
    w_shift_en_nxt  = 1'b0;
    w_valid_nxt     = r_valid;
    w_addr_nxt      = r_addr;
    w_overrun_nxt   = r_overrun;
    w_frame_err_nxt = r_frame_err;

    case (r_state)
      ST_IDLE: begin
        if (!w_csb) w_state_nxt = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (w_csb) begin
          // Frame closed; a partial word is an error, a word boundary is not.
          if (r_cnt != 4'd0) w_frame_err_nxt = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end else if (w_rise) begin
          w_shift_in_nxt = w_sdi;
          w_shift_en_nxt = 1'b1;
          w_cnt_nxt      = r_cnt + 4'd1;   // 15 wraps to 0
          if (r_cnt == 4'd15) w_state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!r_valid) w_valid_nxt = 1'b1;
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          w_addr_nxt  = r_addr + 1'b1;
          if (w_csb) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SHIFT;
            if (w_rise) begin
              w_shift_in_nxt = w_sdi;
              w_shift_en_nxt = 1'b1;
              w_cnt_nxt      = 4'd1;
            end
          end
        end else if (w_rise) begin
          // No room for the bit: drop it and flag the loss.
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
      end
    endcase

    // Clear wins over address increment and flag setting.
    if (clr_i) begin
      w_addr_nxt      = '0;
      w_overrun_nxt   = 1'b0;
      w_frame_err_nxt = 1'b0;
    end
  end

  // Register all control state and outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_shift_in  <= 1'b0;
      r_shift_en  <= 1'b0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift_in  <= w_shift_in_nxt;
      r_shift_en  <= w_shift_en_nxt;
      r_valid     <= w_valid_nxt;
      r_addr      <= w_addr_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign bus.shift_in_o   = r_shift_in;
  assign bus.shift_en_o   = r_shift_en;
  assign bus.word_valid_o = r_valid;
  assign bus.addr_o       = r_addr;
  assign busy_o           = r_busy;
  assign overrun_o        = r_overrun;
  assign frame_err_o      = r_frame_err;

endmodule
